// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Moore main control unit for the 16-bit multicycle processor.
//               Sequences fetch/decode/execute/memory/write-back, decodes the
//               IR opcode and function field, and counts retired instructions.
//               Optional macro MEM_READY_EN: FETCH, MEM_RD and MEM_WR wait on
//               the mem_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [3:0]       funcfield,
  input  logic             mem_ready,
  output logic             c_ir_write,
  output logic             c_pc_write,
  output logic             c_pc_write_cond,
  output logic             c_branch_ne,
  output logic [1:0]       c_pc_src,
  output logic             c_iord,
  output logic             c_mem_read,
  output logic             c_mem_write,
  output logic             c_reg_write,
  output logic             c_mem_to_reg,
  output logic             c_alu_src_a,
  output logic [1:0]       c_alu_src_b,
  output logic [2:0]       c_alu_op,
  output logic             instr_done,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_SAR = 3'b110;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             mem_ok;

  // Instruction classification from the IR fields
  logic       dec_r, dec_i, dec_zext, dec_lw, dec_sw, dec_br, dec_jmp;
  logic [2:0] dec_op;

`ifdef MEM_READY_EN
  assign mem_ok = mem_ready;
`else
  // Handshake is ignored: memory states always complete in one cycle
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Decode opcode/funcfield into instruction class and ALU operation
  always_comb begin
    dec_r    = 1'b0;
    dec_i    = 1'b0;
    dec_zext = 1'b0;
    dec_lw   = 1'b0;
    dec_sw   = 1'b0;
    dec_br   = 1'b0;
    dec_jmp  = 1'b0;
    dec_op   = ALU_ADD;
    case (opcode)
      4'b1000: begin dec_r = 1'b1; dec_op = ALU_ADD; end
      4'b1100: begin dec_r = 1'b1; dec_op = ALU_SUB; end
      4'b1011: begin dec_r = 1'b1; dec_op = ALU_NND; end
      4'b1111: begin dec_r = 1'b1; dec_op = ALU_OR;  end
      4'b0000: begin
        case (funcfield)
          4'b0001: begin dec_r = 1'b1; dec_op = ALU_SHL; end
          4'b0010: begin dec_r = 1'b1; dec_op = ALU_SHR; end
          4'b0011: begin dec_r = 1'b1; dec_op = ALU_SAR; end
          default: dec_r = 1'b0;
        endcase
      end
      4'b1001: begin dec_i = 1'b1; dec_op = ALU_ADD; end
      4'b1101: begin dec_i = 1'b1; dec_op = ALU_SUB; end
      4'b1010: begin dec_i = 1'b1; dec_zext = 1'b1; dec_op = ALU_ADD; end
      4'b1110: begin dec_i = 1'b1; dec_zext = 1'b1; dec_op = ALU_SUB; end
      4'b0111: begin dec_i = 1'b1; dec_zext = 1'b1; dec_op = ALU_NND; end
      4'b0110: begin dec_i = 1'b1; dec_zext = 1'b1; dec_op = ALU_OR;  end
      4'b0001: dec_lw  = 1'b1;
      4'b0010: dec_sw  = 1'b1;
      4'b0100: dec_br  = 1'b1;
      4'b0101: dec_br  = 1'b1;
      4'b0011: dec_jmp = 1'b1;
      default: dec_r   = 1'b0;
    endcase
  end

  // State register; reset restarts at FETCH regardless of current state
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore outputs; everything is forced low during reset
  always_comb begin
    state_d         = state_q;
    c_ir_write      = 1'b0;
    c_pc_write      = 1'b0;
    c_pc_write_cond = 1'b0;
    c_branch_ne     = 1'b0;
    c_pc_src        = 2'b00;
    c_iord          = 1'b0;
    c_mem_read      = 1'b0;
    c_mem_write     = 1'b0;
    c_reg_write     = 1'b0;
    c_mem_to_reg    = 1'b0;
    c_alu_src_a     = 1'b0;
    c_alu_src_b     = 2'b00;
    c_alu_op        = ALU_ADD;
    instr_done      = 1'b0;
    halt            = 1'b0;
    case (state_q)
      S_FETCH: begin
        c_mem_read  = 1'b1;
        c_alu_src_b = 2'b01;
        if (mem_ok) begin
          c_ir_write = 1'b1;
          c_pc_write = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut <= PC + sext(imm8): branch target ready for BRANCH
        c_alu_src_b = 2'b10;
        if (dec_r)        state_d = S_EXEC_R;
        else if (dec_i)   state_d = S_EXEC_I;
        else if (dec_lw || dec_sw) state_d = S_MEM_ADDR;
        else if (dec_br)  state_d = S_BRANCH;
        else if (dec_jmp) state_d = S_JUMP;
        else              state_d = S_ILLEGAL;
      end
      S_EXEC_R: begin
        c_alu_src_a = 1'b1;
        c_alu_op    = dec_op;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = dec_zext ? 2'b11 : 2'b10;
        c_alu_op    = dec_op;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        c_reg_write = 1'b1;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
        state_d     = dec_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        c_mem_read = 1'b1;
        c_iord     = 1'b1;
        if (mem_ok) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        c_reg_write  = 1'b1;
        c_mem_to_reg = 1'b1;
        instr_done   = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        c_mem_write = 1'b1;
        c_iord      = 1'b1;
        if (mem_ok) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_BRANCH: begin
        c_alu_src_a     = 1'b1;
        c_alu_op        = ALU_SUB;
        c_pc_write_cond = 1'b1;
        c_pc_src        = 2'b01;
        c_branch_ne     = opcode[0];
        instr_done      = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        c_pc_write = 1'b1;
        c_pc_src   = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        halt = 1'b1;
      end
      default: state_d = S_ILLEGAL;
    endcase
    if (rst) begin
      c_ir_write      = 1'b0;
      c_pc_write      = 1'b0;
      c_pc_write_cond = 1'b0;
      c_branch_ne     = 1'b0;
      c_pc_src        = 2'b00;
      c_iord          = 1'b0;
      c_mem_read      = 1'b0;
      c_mem_write     = 1'b0;
      c_reg_write     = 1'b0;
      c_mem_to_reg    = 1'b0;
      c_alu_src_a     = 1'b0;
      c_alu_src_b     = 2'b00;
      c_alu_op        = ALU_ADD;
      instr_done      = 1'b0;
      halt            = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)             count_q <= '0;
    else if (instr_done) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Moore-style main control unit for the 16-bit multicycle processor. It sequences every instruction through fetch, decode, execute, memory and write-back. It drives the instruction register's write enable, plus PC, memory, register-file and ALU control. It decodes the opcode and function field captured by the instruction register and keeps a retired-instruction counter for bring-up.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- opcode  input  4  IR opcode field, bits 15:12
- funcfield  input  4  IR function field, bits 3:0
- mem_ready  input  1  memory handshake, used only with MEM_READY_EN
- c_ir_write  output  1  IR load enable
- c_pc_write  output  1  unconditional PC write
- c_pc_write_cond  output  1  PC write gated by datapath branch compare
- c_branch_ne  output  1  0 = be (write on zero), 1 = bne (write on nonzero)
- c_pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target
- c_iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- c_mem_read  output  1  memory read strobe
- c_mem_write  output  1  memory write strobe
- c_reg_write  output  1  register-file write
- c_mem_to_reg  output  1  write-back data select: 1 = MDR, 0 = ALUOut
- c_alu_src_a  output  1  ALU A select: 0 = PC, 1 = reg A
- c_alu_src_b  output  2  ALU B select: 00 reg B, 01 constant 1, 10 sign-ext imm8, 11 zero-ext imm8
- c_alu_op  output  3  000 add, 001 sub, 010 nand, 011 or, 100 shl, 101 shr, 110 sar
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- halt  output  1  high while in ILLEGAL
- instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ILLEGAL.
- FETCH:
  - mem_read=1, iord=0, ir_write=1.
  - alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00, pc_write=1.
  - Always goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=add; this precomputes the branch target into ALUOut.
  - Dispatch on the opcode now held in the IR.
- Opcode dispatch from DECODE:
  - 1000 add, 1100 sub, 1011 lnandr, 1111 lorr -> EXEC_R.
  - 0000 with funcfield 0001 shl, 0010 shr, 0011 sar -> EXEC_R.
  - 0000 with any other funcfield -> ILLEGAL.
  - 1001 addimex, 1101 subimex -> EXEC_I with src_b=10.
  - 1010 addimz, 1110 subimz, 0111 lnandim, 0110 lorim -> EXEC_I with src_b=11.
  - 0001 lw, 0010 sw -> MEM_ADDR.
  - 0100 be, 0101 bne -> BRANCH.
  - 0011 jmp -> JUMP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from opcode/funcfield; goes to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b per the dispatch above, alu_op from opcode; goes to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1; goes to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add; goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1; goes to FETCH.
- MEM_WR: mem_write=1, iord=1, instr_done=1; goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_src=01, branch_ne=opcode[0], instr_done=1; goes to FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1; goes to FETCH.
- ILLEGAL:
  - halt=1, all strobes 0, no exit except rst.
  - Does not increment instr_count.
- Every output not listed for a state is 0.
- instr_count increments by 1 on each cycle with instr_done=1.

## Timing
- All outputs are combinational from the registered state and forced to 0 while rst=1.
- Reset values: every output is 0; state becomes FETCH and instr_count becomes 0 on the first rising edge with rst=1.
- The first FETCH occurs in the cycle after rst deasserts.
- The IR captures on the edge ending FETCH, so opcode and funcfield are sampled only in DECODE and later.
- Cycles per instruction: R-type and I-type 4, lw 5, sw 4, be/bne 3, jmp 3.
- rst asserted in any state, mid-instruction included, aborts on the next edge. No partial memory or register write occurs after that edge.
- instr_count at all-ones plus one retire wraps to 0.

## Configuration
- MEM_READY_EN defined:
  - FETCH, MEM_RD and MEM_WR hold their state and outputs while mem_ready=0.
  - They advance on the first cycle with mem_ready=1.
  - ir_write, pc_write and instr_done are asserted only in the cycle where mem_ready=1.
- MEM_READY_EN undefined: mem_ready is ignored and memory states last exactly one cycle.

## Test plan
- Reset, then add (opcode 1000): state sequence FETCH, DECODE, EXEC_R, ALU_WB; reg_write in cycle 4; instr_count=1.
- lw (0001) then sw (0010): lw takes 5 cycles with mem_to_reg=1 in MEM_WB; sw takes 4 cycles with mem_write=1 and iord=1 only in MEM_WR; instr_count=2.
- be (0100), bne (0101), jmp (0011): each takes 3 cycles; branch_ne=0 for be and 1 for bne; jmp asserts pc_src=10 with pc_write=1.
- Opcode 0000 with funcfield 0010 -> EXEC_R with alu_op=101; funcfield 0111 -> ILLEGAL with halt=1 held, instr_count unchanged; rst then returns to FETCH.
- rst asserted during MEM_RD of lw: the next cycle has all outputs 0, and FETCH follows after rst deasserts; instr_count=0.
- With MEM_READY_EN: mem_ready low for 3 cycles in FETCH -> FETCH held 4 cycles with ir_write pulsed once; add then completes in 7 cycles total.
